// File: rtl/bf_pkg.sv
// Shared definitions for the radix-2 butterfly pipeline.
// Build option: BF_SATURATE_EN selects clamping instead of wrapping when a
// result is narrowed back to WIDTH bits.
package bf_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;

  // Intermediate arithmetic is done in a generous signed width so the
  // WIDTH+1 sums and 2*WIDTH+1 product combines never lose a carry.
  localparam int XW = 64;
  typedef logic signed [XW-1:0] wide_t;

  function automatic wide_t max_of(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t min_of(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  // True when v is representable as a w-bit two's complement value.
  function automatic logic fits(input wide_t v, input int w);
    return (v <= max_of(w)) && (v >= min_of(w));
  endfunction

  // Narrowing: the caller keeps the low w bits, so the default build wraps.
  function automatic wide_t narrow(input wide_t v, input int w);
`ifdef BF_SATURATE_EN
    if (v > max_of(w)) return max_of(w);
    if (v < min_of(w)) return min_of(w);
`endif
    return v;
  endfunction

  // Half an LSB of the result, added once before dropping frac bits.
  function automatic wide_t rnd_const(input int frac);
    return (frac > 0) ? (wide_t'(1) <<< (frac - 1)) : wide_t'(0);
  endfunction

endpackage

// File: rtl/bf_cmul.sv
// Twiddle multiply stages: S2 forms the four partial products, S3 combines,
// rounds half-up once per output and narrows. Sticky overflow on narrowing.
module bf_cmul
  import bf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x_re,
  input  logic [WIDTH-1:0] x_im,
  input  logic [WIDTH-1:0] w_re,
  input  logic [WIDTH-1:0] w_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_re,
  output logic [WIDTH-1:0] y_im,
  output logic             ovf
);

  logic [2:1] vld_pipe;
  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  wide_t re_w, im_w;

  // S2: full-width partial products
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (en) begin
      vld_pipe[1] <= in_valid;
      p_rr <= (2*WIDTH)'($signed(x_re)) * (2*WIDTH)'($signed(w_re));
      p_ii <= (2*WIDTH)'($signed(x_im)) * (2*WIDTH)'($signed(w_im));
      p_ri <= (2*WIDTH)'($signed(x_re)) * (2*WIDTH)'($signed(w_im));
      p_ir <= (2*WIDTH)'($signed(x_im)) * (2*WIDTH)'($signed(w_re));
    end
  end

  // Combine, add half LSB, drop fractional bits (floor shift)
  always_comb begin
    re_w = ((wide_t'(p_rr) - wide_t'(p_ii)) + rnd_const(FRAC)) >>> FRAC;
    im_w = ((wide_t'(p_ri) + wide_t'(p_ir)) + rnd_const(FRAC)) >>> FRAC;
  end

  // S3: narrowed result register and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      y_re <= '0;
      y_im <= '0;
      ovf  <= 1'b0;
    end else if (en) begin
      vld_pipe[2] <= vld_pipe[1];
      y_re <= WIDTH'(narrow(re_w, WIDTH));
      y_im <= WIDTH'(narrow(im_w, WIDTH));
      if (vld_pipe[1] && !(fits(re_w, WIDTH) && fits(im_w, WIDTH)))
        ovf <= 1'b1;
    end
  end

  assign out_valid = vld_pipe[2];

endmodule

// File: rtl/bf_radix2_pipe.sv
// Pipelined radix-2 DIF butterfly: Y0 = A+B, Y1 = (A-B)*W, 3 register stages
// under a single stall-all enable. Build option: BF_SATURATE_EN (clamp on
// narrowing instead of wrap).
module bf_radix2_pipe
  import bf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             scale,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  input  logic [WIDTH-1:0] w_re,
  input  logic [WIDTH-1:0] w_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y0_re,
  output logic [WIDTH-1:0] y0_im,
  output logic [WIDTH-1:0] y1_re,
  output logic [WIDTH-1:0] y1_im,
  output logic             ovf
);

  logic en;
  logic s1_vld, s1_ovf, ovf_s1, ovf_cm;
  logic [WIDTH-1:0] y0r_s1, y0i_s1, xr_s1, xi_s1, wr_s1, wi_s1;
  logic [WIDTH-1:0] y0r_s2, y0i_s2;
  wide_t sum_re, sum_im, dif_re, dif_im;

  // Whole pipe moves together unless a held result is blocking the output.
  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  // S1 arithmetic: sum/difference with optional halving, overflow detect
  always_comb begin
    sum_re = wide_t'($signed(a_re)) + wide_t'($signed(b_re));
    sum_im = wide_t'($signed(a_im)) + wide_t'($signed(b_im));
    dif_re = wide_t'($signed(a_re)) - wide_t'($signed(b_re));
    dif_im = wide_t'($signed(a_im)) - wide_t'($signed(b_im));
    if (scale) begin
      sum_re = sum_re >>> 1;
      sum_im = sum_im >>> 1;
      dif_re = dif_re >>> 1;
      dif_im = dif_im >>> 1;
    end
    s1_ovf = !(fits(sum_re, WIDTH) && fits(sum_im, WIDTH) &&
               fits(dif_re, WIDTH) && fits(dif_im, WIDTH));
  end

  // S1 register: Y0, X and the twiddle travel together into the multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      ovf_s1 <= 1'b0;
      y0r_s1 <= '0;
      y0i_s1 <= '0;
      xr_s1  <= '0;
      xi_s1  <= '0;
      wr_s1  <= '0;
      wi_s1  <= '0;
    end else if (en) begin
      s1_vld <= in_valid;
      y0r_s1 <= WIDTH'(narrow(sum_re, WIDTH));
      y0i_s1 <= WIDTH'(narrow(sum_im, WIDTH));
      xr_s1  <= WIDTH'(narrow(dif_re, WIDTH));
      xi_s1  <= WIDTH'(narrow(dif_im, WIDTH));
      wr_s1  <= w_re;
      wi_s1  <= w_im;
      if (in_valid && s1_ovf) ovf_s1 <= 1'b1;
    end
  end

  // Y0 delay line matching the two multiplier stages
  always_ff @(posedge clk) begin
    if (rst) begin
      y0r_s2 <= '0;
      y0i_s2 <= '0;
      y0_re  <= '0;
      y0_im  <= '0;
    end else if (en) begin
      y0r_s2 <= y0r_s1;
      y0i_s2 <= y0i_s1;
      y0_re  <= y0r_s2;
      y0_im  <= y0i_s2;
    end
  end

  bf_cmul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_cmul (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (s1_vld),
    .x_re      (xr_s1),
    .x_im      (xi_s1),
    .w_re      (wr_s1),
    .w_im      (wi_s1),
    .out_valid (out_valid),
    .y_re      (y1_re),
    .y_im      (y1_im),
    .ovf       (ovf_cm)
  );

  assign ovf = ovf_s1 | ovf_cm;

endmodule

// File: tb/tb_bf_radix2_pipe.sv
// Bench for bf_radix2_pipe: spec-level arithmetic model feeding a FIFO of
// expected results, checked every cycle a result is presented, plus
// hand-computed literal expectations for the directed vectors.
module tb_bf_radix2_pipe;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, scale, out_valid, out_ready, ovf;
  logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic [15:0] y0_re, y0_im, y1_re, y1_im;

  int checks = 0, failures = 0;
  int acc_cnt = 0, out_cnt = 0;

  typedef struct {
    logic [15:0] y0r, y0i, y1r, y1i;
    bit          ovc;
  } exp_t;

  exp_t q[$];
  bit   exp_ovf = 1'b0;

  always #5 clk = ~clk;

  bf_radix2_pipe #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .scale(scale), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im), .out_valid(out_valid), .out_ready(out_ready),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit oob(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic logic [15:0] nar(input longint v);
`ifdef BF_SATURATE_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // Butterfly in plain integer arithmetic, Q7.8 components
  function automatic exp_t model(input logic [15:0] ar_, ai_, br_, bi_, wr_, wi_,
                                 input logic sc);
    exp_t e;
    longint ar, ai, br, bi, wr, wi, sr, si, dr, di, xr, xi, pr, pi;
    ar = longint'($signed(ar_)); ai = longint'($signed(ai_));
    br = longint'($signed(br_)); bi = longint'($signed(bi_));
    wr = longint'($signed(wr_)); wi = longint'($signed(wi_));
    sr = ar + br; si = ai + bi; dr = ar - br; di = ai - bi;
    if (sc) begin
      sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
    end
    e.ovc = oob(sr) | oob(si) | oob(dr) | oob(di);
    e.y0r = nar(sr); e.y0i = nar(si);
    xr = longint'($signed(nar(dr)));
    xi = longint'($signed(nar(di)));
    pr = (xr * wr - xi * wi + 128) >>> 8;
    pi = (xr * wi + xi * wr + 128) >>> 8;
    e.ovc = e.ovc | oob(pr) | oob(pi);
    e.y1r = nar(pr); e.y1i = nar(pi);
    return e;
  endfunction

  // Scoreboard bookkeeping on each handshake
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(a_re, a_im, b_re, b_im, w_re, w_im, scale);
        exp_ovf = exp_ovf | e.ovc;
        e.ovc = exp_ovf;
        q.push_back(e);
        acc_cnt++;
      end
    end
  end

  // Compare presented result against the head of the expected FIFO
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_output: got out_valid=1 expected no sample in flight");
      end else begin
        chk("model_y0_re", y0_re, q[0].y0r);
        chk("model_y0_im", y0_im, q[0].y0i);
        chk("model_y1_re", y1_re, q[0].y1r);
        chk("model_y1_im", y1_im, q[0].y1i);
        if (q[0].ovc) chk("model_ovf", ovf, 1);
      end
    end
  end

  task automatic drive(input logic [15:0] ar, ai, br, bi, wr, wi, input logic sc);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    scale = sc; in_valid = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send1(input logic [15:0] ar, ai, br, bi, wr, wi, input logic sc);
    int c0;
    c0 = acc_cnt;
    drive(ar, ai, br, bi, wr, wi, sc);
    for (int k = 0; k < 20 && acc_cnt == c0; k++) @(negedge clk);
    if (acc_cnt == c0) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic bp_sample(input int i);
    drive(16'(16'h0100 * (i + 1)), 16'(16'h0010 * i), 16'(16'h0030 * i),
          16'hFFC0, 16'h00B5, 16'hFF4B, 1'(i % 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, o0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; scale = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_y0_re", y0_re, 0);
    chk("rst_y1_re", y1_re, 0);
    chk("rst_y1_im", y1_im, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Basic vector with latency check
    drive(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("latency_not_early", out_valid, 0);
    @(negedge clk);
    chk("latency_3", out_valid, 1);
    chk("t1_y0_re", y0_re, 16'h0180);
    chk("t1_y0_im", y0_im, 16'h0000);
    chk("t1_y1_re", y1_re, 16'h0080);
    chk("t1_y1_im", y1_im, 16'h0000);
    chk("t1_ovf", ovf, 0);

    // W = -j
    send1(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'hFF00, 1'b0);
    wait_out();
    chk("t2_y1_re", y1_re, 16'h0000);
    chk("t2_y1_im", y1_im, 16'hFF80);

    // Round half up on the twiddle product
    send1(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 1'b0);
    wait_out();
    chk("rnd_up_y1_re", y1_re, 16'h0001);
    send1(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b0);
    wait_out();
    chk("rnd_neg_y1_re", y1_re, 16'h0000);

    // Overflow on the sum
    send1(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    wait_out();
`ifdef BF_SATURATE_EN
    chk("ovf_y0_re", y0_re, 16'h7FFF);
`else
    chk("ovf_y0_re", y0_re, 16'hFE00);
`endif
    chk("ovf_set", ovf, 1);
    @(negedge clk);
    chk("ovf_sticky", ovf, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ovf_cleared", ovf, 0);
    send1(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 1'b1);
    wait_out();
    chk("scaled_y0_re", y0_re, 16'h7F00);
    chk("scaled_ovf", ovf, 0);
    @(negedge clk);

    // Backpressure: only three fit while the output is blocked
    out_ready = 1'b0;
    base = acc_cnt;
    for (int c = 0; c < 8; c++) begin
      if (acc_cnt - base < 5) bp_sample(acc_cnt - base); else in_valid = 1'b0;
      @(negedge clk);
    end
    chk("bp_accepted", acc_cnt - base, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    o0 = out_cnt;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (acc_cnt - base < 5) bp_sample(acc_cnt - base); else in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_burst_outputs", out_cnt - o0, 5);
    chk("bp_all_accepted", acc_cnt - base, 5);
    repeat (4) @(negedge clk);

    // Reset with two samples in flight
    bp_sample(1);
    @(negedge clk);
    bp_sample(2);
    @(negedge clk);
    rst = 1'b1;
    bp_sample(3);
    @(negedge clk);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_ovf", ovf, 0);
    chk("rstmid_in_ready", in_ready, 1);
    rst = 1'b0;
    in_valid = 1'b0;
    o0 = out_cnt;
    repeat (6) @(negedge clk);
    chk("rstmid_no_stale", out_cnt - o0, 0);

    chk("final_queue_empty", q.size(), 0);
    chk("final_ovf", ovf, exp_ovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
